// File: rtl/sprite_fetch_pkg.sv
// Constants and helpers shared by the sprite fetch pipeline:
// sprite geometry, ROM layout bases and the per-axis square locator.
package sprite_fetch_pkg;

    localparam int SPRITE_SQ    = 60;
    localparam int SPRITE_WORDS = 3600;
    localparam int BOARD_PIX    = 8 * SPRITE_SQ;

    localparam logic [16:0] DIGIT_BASE = 17'd43200;

    typedef logic [3:0] piece_code_t;

    // ROM image order: pawn_b, pawn_w, knight_b, knight_w, bishop_b/w,
    // rook_b/w, queen_b/w, king_b/w. Codes 0 and 13..15 carry no sprite.
    localparam logic [16:0] PIECE_BASE [0:15] = '{
        17'd0,
        17'd0,     17'd3600,  17'd7200,  17'd10800,
        17'd14400, 17'd18000, 17'd21600, 17'd25200,
        17'd28800, 17'd32400, 17'd36000, 17'd39600,
        17'd0,     17'd0,     17'd0
    };

    typedef struct packed {
        logic [2:0] idx;
        logic [5:0] off;
    } axis_t;

    function automatic logic is_piece(input piece_code_t c);
        return (c >= 4'd1) && (c <= 4'd12);
    endfunction

    // Square index and offset along one axis without a divider:
    // the index is the highest k with r >= k*SQ.
    function automatic axis_t axis_locate(input logic [8:0] r);
        axis_t a;
        a.idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r >= 9'(k * SPRITE_SQ)) a.idx = 3'(k);
        end
        a.off = 6'(r - 9'(a.idx) * 9'(SPRITE_SQ));
        return a;
    endfunction

endpackage

// File: rtl/sprite_fetch_sq_locate.sv
// Stage-0 board geometry: board-relative rx/ry -> file, rank, offsets.
// Ports: rx, ry (signed board-relative pixel), file, rank, ox, oy, in_board.
module sprite_fetch_sq_locate
    import sprite_fetch_pkg::*;
(
    input  logic signed [10:0] rx,
    input  logic signed [10:0] ry,
    output logic        [2:0]  file,
    output logic        [2:0]  rank,
    output logic        [5:0]  ox,
    output logic        [5:0]  oy,
    output logic               in_board
);

    axis_t ax;
    axis_t ay;

    always_comb begin
        in_board = !rx[10] && !ry[10] &&
                   (rx < 11'(BOARD_PIX)) && (ry < 11'(BOARD_PIX));
        ax   = axis_locate(rx[8:0]);
        ay   = axis_locate(ry[8:0]);
        file = ax.idx;
        rank = ay.idx;
        ox   = ax.off;
        oy   = ay.off;
    end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite ROM initiator: scan position + board contents -> ROM address,
// then aligned RGB pixel with opacity flag two cycles after the strobe.
// Ports: Clk, Reset_n (async low), pix_in_valid, DrawX, DrawY, sq_idx,
// piece_code, read_address, rom_data, pixel_rgb, pixel_opaque,
// pixel_valid, cursor_sq, hilite.
// Optional: define SPRITE_HILITE_EN for the cursor border highlight.
module sprite_fetch
    import sprite_fetch_pkg::*;
#(
    parameter int          BOARD_X0 = 80,
    parameter int          BOARD_Y0 = 0,
    parameter int          SQ       = SPRITE_SQ,
    parameter logic [23:0] KEY_RGB  = 24'hFF00FF
)(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_in_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [5:0]  sq_idx,
    input  logic [3:0]  piece_code,
    output logic [16:0] read_address,
    input  logic [23:0] rom_data,
    output logic [23:0] pixel_rgb,
    output logic        pixel_opaque,
    output logic        pixel_valid,
    input  logic [5:0]  cursor_sq,
    output logic        hilite
);

    logic signed [10:0] rx;
    logic signed [10:0] ry;
    logic [2:0]  file;
    logic [2:0]  rank;
    logic [5:0]  ox;
    logic [5:0]  oy;
    logic        in_board;
    logic        fetch;
    logic [16:0] oy_ext;
    logic [16:0] sprite_off;

    logic [16:0] read_address_q, read_address_d;
    logic        fetch_q, fetch_d;
    logic        v1_q, v1_d;
    logic [23:0] pixel_rgb_q, pixel_rgb_d;
    logic        pixel_opaque_q, pixel_opaque_d;
    logic        pixel_valid_q, pixel_valid_d;

    assign rx = $signed({1'b0, DrawX}) - 11'(BOARD_X0);
    assign ry = $signed({1'b0, DrawY}) - 11'(BOARD_Y0);

    sprite_fetch_sq_locate u_loc (
        .rx       (rx),
        .ry       (ry),
        .file     (file),
        .rank     (rank),
        .ox       (ox),
        .oy       (oy),
        .in_board (in_board)
    );

    assign sq_idx = in_board ? {rank, file} : 6'd0;

    always_comb begin
        fetch      = pix_in_valid && in_board && is_piece(piece_code);
        oy_ext     = 17'(oy);
        // oy*60 as a shift-subtract
        sprite_off = (oy_ext << 6) - (oy_ext << 2) + 17'(ox);

        read_address_d = read_address_q;
        if (fetch) read_address_d = PIECE_BASE[piece_code] + sprite_off;
        fetch_d = fetch;
        v1_d    = pix_in_valid;

        pixel_valid_d  = v1_q;
        pixel_rgb_d    = fetch_q ? rom_data : 24'd0;
        pixel_opaque_d = fetch_q && (rom_data != KEY_RGB);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address_q <= '0;
            fetch_q        <= 1'b0;
            v1_q           <= 1'b0;
            pixel_rgb_q    <= '0;
            pixel_opaque_q <= 1'b0;
            pixel_valid_q  <= 1'b0;
        end else begin
            read_address_q <= read_address_d;
            fetch_q        <= fetch_d;
            v1_q           <= v1_d;
            pixel_rgb_q    <= pixel_rgb_d;
            pixel_opaque_q <= pixel_opaque_d;
            pixel_valid_q  <= pixel_valid_d;
        end
    end

    assign read_address = read_address_q;
    assign pixel_rgb    = pixel_rgb_q;
    assign pixel_opaque = pixel_opaque_q;
    assign pixel_valid  = pixel_valid_q;

`ifdef SPRITE_HILITE_EN
    logic hl1_q, hl1_d;
    logic hilite_q, hilite_d;

    always_comb begin
        hl1_d = pix_in_valid && in_board && (sq_idx == cursor_sq) &&
                ((ox < 6'd2) || (ox > 6'd57) ||
                 (oy < 6'd2) || (oy > 6'd57));
        hilite_d = hl1_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hl1_q    <= 1'b0;
            hilite_q <= 1'b0;
        end else begin
            hl1_q    <= hl1_d;
            hilite_q <= hilite_d;
        end
    end

    assign hilite = hilite_q;
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor_sq;
    assign hilite        = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: directed pixels push expected
// results; a negedge monitor pops and compares on pixel_valid.
module tb_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_in_valid;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [5:0]  sq_idx;
    logic [3:0]  piece_code;
    logic [16:0] read_address;
    logic [23:0] rom_data;
    logic [23:0] pixel_rgb;
    logic        pixel_opaque;
    logic        pixel_valid;
    logic [5:0]  cursor_sq;
    logic        hilite;
    logic        key_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [23:0] rgb;
        logic        op;
        logic        hl;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    sprite_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_in_valid (pix_in_valid),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .sq_idx       (sq_idx),
        .piece_code   (piece_code),
        .read_address (read_address),
        .rom_data     (rom_data),
        .pixel_rgb    (pixel_rgb),
        .pixel_opaque (pixel_opaque),
        .pixel_valid  (pixel_valid),
        .cursor_sq    (cursor_sq),
        .hilite       (hilite)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // ROM model: address as data, except the two directed test words
    assign rom_data =
        (read_address == 17'd11405) ?
            (key_flag ? 24'hFF00FF : 24'h123456) :
            {7'd0, read_address};

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (pixel_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got valid expected none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pixel_rgb", pixel_rgb, e.rgb);
                    chk("pixel_opaque", pixel_opaque, e.op);
                    chk("hilite", hilite, e.hl);
                    chk("latency", cyc - e.cyc, 2);
                end
            end else begin
                chk("hilite_idle", hilite, 1'b0);
            end
        end
    end

    task automatic send(input int x, input int y, input int code,
                        input int sq, input int addr,
                        input logic [23:0] rgb, input logic op,
                        input logic hl);
        exp_t e;
        pix_in_valid = 1'b1;
        DrawX        = 10'(x);
        DrawY        = 10'(y);
        piece_code   = 4'(code);
        #1;
        chk("sq_idx", sq_idx, sq);
        e.rgb = rgb;
        e.op  = op;
`ifdef SPRITE_HILITE_EN
        e.hl  = hl;
`else
        e.hl  = 1'b0;
`endif
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        chk("read_address", read_address, addr);
    endtask

    task automatic idle(input int n);
        pix_in_valid = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset_n      = 1'b0;
        pix_in_valid = 1'b1;
        DrawX        = 10'd145;
        DrawY        = 10'd10;
        piece_code   = 4'd4;
        cursor_sq    = 6'd1;
        key_flag     = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_read_address", read_address, 0);
        chk("rst_pixel_rgb", pixel_rgb, 0);
        chk("rst_pixel_opaque", pixel_opaque, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_hilite", hilite, 0);
        pix_in_valid = 1'b0;
        Reset_n      = 1'b1;
        idle(2);

        // x, y, code, sq_idx, address, rgb, opaque, hilite
        send(145, 10, 4, 1, 11405, 24'h123456, 1, 0);
        send(141, 10, 4, 1, 11401, 24'd11401, 1, 1);
        send(80, 479, 12, 56, 43140, 24'd43140, 1, 0);
        send(79, 10, 4, 0, 43140, 24'd0, 0, 0);
        send(560, 10, 4, 0, 43140, 24'd0, 0, 0);
        send(145, 10, 0, 1, 43140, 24'd0, 0, 0);
        send(145, 10, 13, 1, 43140, 24'd0, 0, 0);
        idle(1);
        send(139, 0, 1, 0, 59, 24'd59, 1, 0);
        send(140, 0, 1, 1, 0, 24'd0, 1, 1);
        send(199, 59, 2, 1, 7199, 24'd7199, 1, 1);
        send(200, 60, 3, 10, 7200, 24'd7200, 1, 0);
        idle(4);

        key_flag = 1'b1;
        send(145, 10, 4, 1, 11405, 24'hFF00FF, 0, 0);
        idle(4);

        // reset with a pixel already at the output stage
        pix_in_valid = 1'b1;
        DrawX        = 10'd145;
        DrawY        = 10'd10;
        piece_code   = 4'd4;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n      = 1'b0;
        pix_in_valid = 1'b0;
        #1;
        chk("async_pixel_valid", pixel_valid, 0);
        chk("async_pixel_rgb", pixel_rgb, 0);
        chk("async_read_address", read_address, 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle(3);

        key_flag = 1'b0;
        send(141, 10, 4, 1, 11401, 24'd11401, 1, 1);
        idle(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
